// File: rtl/pipe_chain_pkg.sv
// Shared types and helpers for the elastic pipeline-register chain and the
// hazard logic that consumes its per-slot status.
package pipe_chain_pkg;

    typedef struct packed {
        logic valid;
        logic flush;
    } pipe_ctrl_t;

    // Occupancy can reach DEPTH slots plus one skid entry.
    function automatic int count_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/pipe_chain_slot.sv
// One valid+payload register of the chain: loads when the slot ahead can
// accept, squashes on flush, optionally zeroes payload when it goes empty.
module pipe_slot #(
    parameter int BW            = 32,
    parameter int ZERO_ON_FLUSH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          src_valid_i,
    input  logic [BW-1:0] src_data_i,
    input  logic          flush_i,
    output logic          valid_o,
    output logic          valid_nxt_o,
    output logic [BW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [BW-1:0] data_q, data_d;

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            if (ZERO_ON_FLUSH != 0) data_d = '0;
        end else if (load_i) begin
            valid_d = src_valid_i;
            if (src_valid_i)              data_d = src_data_i;
            else if (ZERO_ON_FLUSH != 0)  data_d = '0;
        end
    end

    // NOTE: payload is reset as well, so out_data reads 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o     = valid_q;
    assign valid_nxt_o = valid_d;
    assign data_o      = data_q;

endmodule

// File: rtl/pipe_chain.sv
// DEPTH-deep elastic register chain with valid/ready backpressure, bubble
// collapsing, per-slot flush and an optional one-entry input skid buffer.
module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int BW            = 32,
    parameter int DEPTH         = 3,
    parameter int SKID          = 1,
    parameter int ZERO_ON_FLUSH = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [BW-1:0]                  in_data,
    output logic                           in_ready,
    input  logic [DEPTH-1:0]               flush,
    output logic                           out_valid,
    output logic [BW-1:0]                  out_data,
    input  logic                           out_ready,
    output logic [count_width(DEPTH)-1:0]  count,
    output logic [DEPTH-1:0]               slot_valid
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] v_q, v_nxt;
    logic [BW-1:0]    d_q   [DEPTH];
    logic [BW-1:0]    src_d [DEPTH];
    pipe_ctrl_t       ctrl  [DEPTH];

    logic          live_q;
    logic          skid_v_q, skid_v_d;
    logic [BW-1:0] skid_d_q, skid_d_d;
    logic [CW-1:0] count_q, count_d;
    logic          hs;

    // A slot is ready when empty or when everything ahead of it moves.
    always_comb begin
        logic acc;
        acc = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = !v_q[i] | acc;
            rdy[i] = acc;
        end
    end

    assign in_ready = live_q & ((SKID != 0) ? !skid_v_q : rdy[0]);
    assign hs       = in_valid & in_ready;

    always_comb begin
        ctrl[0].valid = skid_v_q | hs;
        ctrl[0].flush = flush[0];
        src_d[0]      = skid_v_q ? skid_d_q : in_data;
        for (int i = 1; i < DEPTH; i++) begin
            ctrl[i].valid = v_q[i-1];
            ctrl[i].flush = flush[i];
            src_d[i]      = d_q[i-1];
        end
    end

    always_comb begin
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (SKID != 0) begin
            if (skid_v_q) begin
                if (rdy[0]) skid_v_d = 1'b0;
            end else if (hs && !rdy[0]) begin
                skid_v_d = 1'b1;
                skid_d_d = in_data;
            end
        end
        if (flush[0]) skid_v_d = 1'b0;
        if (ZERO_ON_FLUSH != 0 && !skid_v_d) skid_d_d = '0;
    end

    always_comb begin
        count_d = CW'(skid_v_d);
        for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(v_nxt[i]);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        pipe_slot #(
            .BW            (BW),
            .ZERO_ON_FLUSH (ZERO_ON_FLUSH)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .load_i      (rdy[g]),
            .src_valid_i (ctrl[g].valid),
            .src_data_i  (src_d[g]),
            .flush_i     (ctrl[g].flush),
            .valid_o     (v_q[g]),
            .valid_nxt_o (v_nxt[g]),
            .data_o      (d_q[g])
        );
    end

    // live_q holds in_ready low through reset and the cycle it is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q   <= 1'b0;
            skid_v_q <= 1'b0;
            skid_d_q <= '0;
            count_q  <= '0;
        end else begin
            live_q   <= 1'b1;
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
            count_q  <= count_d;
        end
    end

    assign out_valid  = v_q[DEPTH-1];
    assign out_data   = d_q[DEPTH-1];
    assign slot_valid = v_q;
    assign count      = count_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain (DEPTH=3, SKID=1, ZERO_ON_FLUSH=1):
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_chain;

    localparam int BW    = 32;
    localparam int DEPTH = 3;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid = 1'b0;
    logic [BW-1:0]    in_data  = '0;
    logic             in_ready;
    logic [DEPTH-1:0] flush    = '0;
    logic             out_valid;
    logic [BW-1:0]    out_data;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] slot_valid;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_chain #(
        .BW(BW), .DEPTH(DEPTH), .SKID(1), .ZERO_ON_FLUSH(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count),
        .slot_valid (slot_valid)
    );

    always #5 clk = ~clk;

    // Reference state: slot contents (index DEPTH-1 is the output end) and skid.
    bit            m_v [DEPTH];
    logic [BW-1:0] m_d [DEPTH];
    bit            m_sv;
    logic [BW-1:0] m_sd;
    bit            m_live;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        m_sv   = 1'b0;
        m_sd   = '0;
        m_live = 1'b0;
    endtask

    task automatic compare_outputs();
        int               occ;
        logic [DEPTH-1:0] sv;
        occ = int'(m_sv);
        for (int i = 0; i < DEPTH; i++) begin
            occ  += int'(m_v[i]);
            sv[i] = m_v[i];
        end
        check("out_valid",  64'(out_valid),  64'(m_v[DEPTH-1]));
        check("out_data",   64'(out_data),   64'(m_d[DEPTH-1]));
        check("in_ready",   64'(in_ready),   64'(m_live & !m_sv));
        check("count",      64'(count),      64'(occ));
        check("slot_valid", 64'(slot_valid), 64'(sv));
    endtask

    // Apply one cycle of inputs, predict the state after the edge, then compare.
    task automatic step(input bit iv, input logic [BW-1:0] idata, input bit ordy,
                        input logic [DEPTH-1:0] fl);
        bit            moves [DEPTH+1];
        bit            nv    [DEPTH];
        logic [BW-1:0] nd    [DEPTH];
        bit            accepted, nsv;
        logic [BW-1:0] nsd;
        in_valid  = iv;
        in_data   = idata;
        out_ready = ordy;
        flush     = fl;

        accepted     = iv && m_live && !m_sv;
        moves[DEPTH] = ordy;
        for (int i = DEPTH - 1; i >= 0; i--) moves[i] = !m_v[i] || moves[i+1];
        for (int i = 0; i < DEPTH; i++) begin
            nv[i] = m_v[i];
            nd[i] = m_d[i];
        end
        for (int i = DEPTH - 1; i >= 1; i--) begin
            if (moves[i]) begin
                nv[i] = m_v[i-1];
                nd[i] = m_v[i-1] ? m_d[i-1] : '0;
            end
        end
        if (moves[0]) begin
            if (m_sv)          begin nv[0] = 1'b1; nd[0] = m_sd;  end
            else if (accepted) begin nv[0] = 1'b1; nd[0] = idata; end
            else               begin nv[0] = 1'b0; nd[0] = '0;    end
        end
        nsv = m_sv;
        nsd = m_sd;
        if (m_sv && moves[0]) nsv = 1'b0;
        if (!m_sv && accepted && !moves[0]) begin
            nsv = 1'b1;
            nsd = idata;
        end
        if (fl[0]) nsv = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fl[i]) begin
                nv[i] = 1'b0;
                nd[i] = '0;
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = nv[i];
            m_d[i] = nd[i];
        end
        m_sv   = nsv;
        m_sd   = nsv ? nsd : '0;
        m_live = 1'b1;
        compare_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_out_data",   64'(out_data),   64'd0);
        check("rst_in_ready",   64'(in_ready),   64'd0);
        check("rst_count",      64'(count),      64'd0);
        check("rst_slot_valid", 64'(slot_valid), 64'd0);
        m_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, '0, 1'b0, '0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_count",    64'(count),    64'd0);
    endtask

    initial begin
        m_clear();
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Stream three words with the output always ready.
        step(1'b1, 32'h11, 1'b1, '0);
        step(1'b1, 32'h22, 1'b1, '0);
        step(1'b1, 32'h33, 1'b1, '0);
        check("lat_first_data", 64'(out_data), 64'h11);
        check("lat_peak_count", 64'(count),    64'd3);
        step(1'b0, '0, 1'b1, '0);
        check("lat_second_data", 64'(out_data), 64'h22);
        step(1'b0, '0, 1'b1, '0);
        check("lat_third_data", 64'(out_data), 64'h33);
        step(1'b0, '0, 1'b1, '0);
        check("lat_drained", 64'(out_valid), 64'd0);

        // Stalled output: three slots plus the skid absorb four of five words.
        for (int k = 0; k < 5; k++) step(1'b1, 32'hA1 + k, 1'b0, '0);
        check("full_count",    64'(count),    64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head",     64'(out_data), 64'hA1);
        step(1'b0, '0, 1'b1, '0);
        check("drain_a2", 64'(out_data), 64'hA2);
        step(1'b0, '0, 1'b1, '0);
        check("drain_a3", 64'(out_data), 64'hA3);
        step(1'b0, '0, 1'b1, '0);
        check("drain_a4", 64'(out_data), 64'hA4);
        step(1'b0, '0, 1'b1, '0);
        check("drain_empty", 64'(out_valid), 64'd0);

        // Bubble collapsing behind a stalled tail.
        step(1'b1, 32'hB1, 1'b0, '0);
        step(1'b0, '0,     1'b0, '0);
        step(1'b1, 32'hB2, 1'b0, '0);
        check("bubble_before", 64'(slot_valid), 64'b101);
        step(1'b0, '0, 1'b0, '0);
        check("bubble_after", 64'(slot_valid), 64'b110);
        check("bubble_hold",  64'(out_data),   64'hB1);

        // Squash the middle slot of a full chain; its word never emerges.
        step(1'b1, 32'hB3, 1'b0, '0);
        check("mid_full", 64'(slot_valid), 64'b111);
        step(1'b0, '0, 1'b0, 3'b010);
        check("mid_flush_valid", 64'(slot_valid), 64'b101);
        check("mid_flush_count", 64'(count),      64'd2);
        step(1'b0, '0, 1'b1, '0);
        check("mid_gap", 64'(out_valid), 64'd0);
        step(1'b0, '0, 1'b1, '0);
        check("mid_next_word", 64'(out_data), 64'hB3);
        step(1'b0, '0, 1'b1, '0);

        // flush[0] with a full skid, then with a live handshake.
        for (int k = 0; k < 4; k++) step(1'b1, 32'hC1 + k, 1'b0, '0);
        check("skid_full_count", 64'(count), 64'd4);
        step(1'b1, 32'hC5, 1'b0, 3'b001);
        check("skid_flush_count", 64'(count),      64'd2);
        check("skid_flush_slots", 64'(slot_valid), 64'b110);
        check("skid_flush_ready", 64'(in_ready),   64'd1);
        step(1'b1, 32'hC6, 1'b0, 3'b001);
        check("hs_flush_count", 64'(count), 64'd2);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, '0);

        // Reset in the middle of traffic.
        for (int k = 0; k < 4; k++) step(1'b1, 32'hD1 + k, 1'($urandom_range(0, 1)), '0);
        do_reset();

        // Randomized traffic with occasional flushes and resets.
        for (int n = 0; n < 1500; n++) begin
            logic [DEPTH-1:0] fl;
            for (int i = 0; i < DEPTH; i++) fl[i] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            step(1'($urandom_range(0, 3) != 0), $urandom(),
                 1'($urandom_range(0, 2) != 0), fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
